// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 68k SRAM access controller.
// Holds the FSM state enum, block count and default wait-state count.
package sram_ctrl_pkg;

  localparam int NUM_BLOCKS          = 4;
  localparam int DEFAULT_WAIT_STATES = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    ACK,
    HOLD
  } state_e;

endpackage

// File: rtl/sram_block_select.sv
// Decodes a 2-bit block index into an active-low one-hot chip enable.
// Ports: blk_i (index), en_i (enable), ce_l_o (all high when disabled).
module sram_block_select
  import sram_ctrl_pkg::*;
(
  input  logic [1:0]            blk_i,
  input  logic                  en_i,
  output logic [NUM_BLOCKS-1:0] ce_l_o
);

  always_comb begin
    ce_l_o = '1;
    if (en_i) ce_l_o[blk_i] = 1'b0;
  end

endmodule

// File: rtl/sram_access_controller.sv
// 68k bus to 4x64KB SRAM controller; all outputs registered.
// Ports: 68k strobes/RW/Address in; SRAM CE/UB/LB/OE/WE and Dtack_L out.
module sram_access_controller
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic                  Clock,
  input  logic                  Reset_L,
  input  logic                  AS_L,
  input  logic                  UDS_L,
  input  logic                  LDS_L,
  input  logic                  RW,
  input  logic                  SRamSelect_H,
  input  logic [16:0]           Address,
  output logic [NUM_BLOCKS-1:0] SRam_CE_L,
  output logic                  SRam_UB_L,
  output logic                  SRam_LB_L,
  output logic                  SRam_OE_L,
  output logic                  SRam_WE_L,
  output logic                  Dtack_L
);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] blk_q, blk_d;
  logic rw_q, rw_d;
  logic uds_q, uds_d;
  logic lds_q, lds_d;
  logic armed_q, armed_d;

  logic [NUM_BLOCKS-1:0] ce_q, ce_d;
  logic ub_q, ub_d;
  logic lb_q, lb_d;
  logic oe_q, oe_d;
  logic we_q, we_d;
  logic dtack_q, dtack_d;

  logic start;
  logic busy;
  logic unused_addr;

  assign unused_addr = ^Address[14:0];

  // armed: AS_L seen high since the last start or reset
  assign start = (state_q == IDLE) && !AS_L
              && SRamSelect_H && armed_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    rw_d    = rw_q;
    uds_d   = uds_q;
    lds_d   = lds_q;
    armed_d = AS_L ? 1'b1 : (start ? 1'b0 : armed_q);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          blk_d   = Address[16:15];
          rw_d    = RW;
          uds_d   = UDS_L;
          lds_d   = LDS_L;
        end
      end
      SETUP: begin
        if (AS_L) begin
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES - 1);
        end
      end
      ACCESS: begin
        if (AS_L)             state_d = IDLE;
        else if (cnt_q == '0) state_d = ACK;
        else                  cnt_d   = cnt_q - 4'd1;
      end
      ACK:  state_d = HOLD;
      HOLD: if (AS_L) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) cnt_d = '0;
  end

  // Outputs are derived from the next state so they
  // appear on the same edge the FSM moves.
  assign busy = (state_d != IDLE);

  sram_block_select u_blk_sel (
    .blk_i  (blk_d),
    .en_i   (busy),
    .ce_l_o (ce_d)
  );

  always_comb begin
    ub_d    = busy ? uds_d : 1'b1;
    lb_d    = busy ? lds_d : 1'b1;
    oe_d    = !(busy && rw_d);
    we_d    = !((state_d == ACCESS) && !rw_d);
    dtack_d = !((state_d == ACK) || (state_d == HOLD));
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      rw_q    <= 1'b1;
      uds_q   <= 1'b1;
      lds_q   <= 1'b1;
      armed_q <= 1'b0;
      ce_q    <= '1;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      dtack_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      rw_q    <= rw_d;
      uds_q   <= uds_d;
      lds_q   <= lds_d;
      armed_q <= armed_d;
      ce_q    <= ce_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      dtack_q <= dtack_d;
    end
  end

  assign SRam_CE_L = ce_q;
  assign SRam_UB_L = ub_q;
  assign SRam_LB_L = lb_q;
  assign SRam_OE_L = oe_q;
  assign SRam_WE_L = we_q;
  assign Dtack_L   = dtack_q;

endmodule

// File: tb/tb_sram_access_controller.sv
// Random + directed bench for sram_access_controller at WAIT_STATES 2, 1, 15.
// Reference model works from elapsed cycles since the capturing edge.
module tb_sram_access_controller;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset_L;
  logic        AS_L;
  logic        UDS_L;
  logic        LDS_L;
  logic        RW;
  logic        SRamSelect_H;
  logic [16:0] Address;

  logic [3:0] ce_l [3];
  logic       ub_l [3];
  logic       lb_l [3];
  logic       oe_l [3];
  logic       we_l [3];
  logic       dt_l [3];

  sram_access_controller #(.WAIT_STATES(2)) u_dut0 (
    .Clock(Clock), .Reset_L(Reset_L), .AS_L(AS_L),
    .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW),
    .SRamSelect_H(SRamSelect_H), .Address(Address),
    .SRam_CE_L(ce_l[0]), .SRam_UB_L(ub_l[0]),
    .SRam_LB_L(lb_l[0]), .SRam_OE_L(oe_l[0]),
    .SRam_WE_L(we_l[0]), .Dtack_L(dt_l[0])
  );

  sram_access_controller #(.WAIT_STATES(1)) u_dut1 (
    .Clock(Clock), .Reset_L(Reset_L), .AS_L(AS_L),
    .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW),
    .SRamSelect_H(SRamSelect_H), .Address(Address),
    .SRam_CE_L(ce_l[1]), .SRam_UB_L(ub_l[1]),
    .SRam_LB_L(lb_l[1]), .SRam_OE_L(oe_l[1]),
    .SRam_WE_L(we_l[1]), .Dtack_L(dt_l[1])
  );

  sram_access_controller #(.WAIT_STATES(15)) u_dut2 (
    .Clock(Clock), .Reset_L(Reset_L), .AS_L(AS_L),
    .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW),
    .SRamSelect_H(SRamSelect_H), .Address(Address),
    .SRam_CE_L(ce_l[2]), .SRam_UB_L(ub_l[2]),
    .SRam_LB_L(lb_l[2]), .SRam_OE_L(oe_l[2]),
    .SRam_WE_L(we_l[2]), .Dtack_L(dt_l[2])
  );

  int n_chk;
  int n_pass;
  int edge_n;
  int ws [3];

  bit       act   [3];
  int       s_cyc [3];
  int       lh    [3];
  int       ls    [3];
  logic [1:0] mblk [3];
  bit       mrw   [3];
  bit       muds  [3];
  bit       mlds  [3];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [8:0] dut_out(int i);
    return {ce_l[i], ub_l[i], lb_l[i], oe_l[i], we_l[i], dt_l[i]};
  endfunction

  // k = cycles since the capturing cycle N: 1 setup,
  // 2..1+ws access, 2+ws onward acknowledge/hold
  function automatic logic [8:0] model_out(int i);
    int k;
    logic [3:0] ce;
    logic we;
    logic dt;
    if (!act[i]) return 9'h1FF;
    k  = edge_n - s_cyc[i];
    ce = ~(4'b0001 << mblk[i]);
    we = !(!mrw[i] && k >= 2 && k <= 1 + ws[i]);
    dt = !(k >= 2 + ws[i]);
    return {ce, muds[i], mlds[i], !mrw[i], we, dt};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0;
      lh[i]  = -1;
      ls[i]  = edge_n;
    end
  endtask

  task automatic model_edge();
    int kp;
    for (int i = 0; i < 3; i++) begin
      if (act[i]) begin
        kp = edge_n - 1 - s_cyc[i];
        if (AS_L && ((kp >= 1 && kp <= 1 + ws[i])
                     || kp >= 3 + ws[i]))
          act[i] = 1'b0;
      end else if (!AS_L && SRamSelect_H && lh[i] > ls[i]) begin
        act[i]   = 1'b1;
        s_cyc[i] = edge_n - 1;
        ls[i]    = edge_n;
        mblk[i]  = Address[16:15];
        mrw[i]   = RW;
        muds[i]  = UDS_L;
        mlds[i]  = LDS_L;
      end
      if (AS_L) lh[i] = edge_n;
    end
  endtask

  task automatic step(string tag);
    @(posedge Clock);
    edge_n++;
    if (!Reset_L) model_reset();
    else model_edge();
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_ws%0d", tag, ws[i]), dut_out(i), model_out(i));
  endtask

  task automatic pulse_reset();
    #1 Reset_L = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("async_rst_ws%0d", ws[i]), dut_out(i), 9'h1FF);
    model_reset();
    #1 Reset_L = 1'b1;
  endtask

  task automatic rand_fields();
    Address      = 17'($urandom);
    RW           = 1'($urandom);
    UDS_L        = 1'($urandom);
    LDS_L        = 1'($urandom);
    SRamSelect_H = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    ws[0] = 2; ws[1] = 1; ws[2] = 15;
    n_chk = 0; n_pass = 0; edge_n = 0;
    Reset_L = 1'b0; AS_L = 1'b1; SRamSelect_H = 1'b0;
    Address = '0; RW = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    model_reset();
    repeat (3) step("reset");
    Reset_L = 1'b1;
    repeat (2) step("idle");

    Address = 17'h0_8000; RW = 1'b1;
    UDS_L = 1'b0; LDS_L = 1'b0; SRamSelect_H = 1'b1; AS_L = 1'b0;
    repeat (20) step("read");
    AS_L = 1'b1;
    repeat (2) step("read_end");

    Address = 17'h1_C000; RW = 1'b0;
    UDS_L = 1'b1; LDS_L = 1'b0; AS_L = 1'b0;
    repeat (20) step("write");
    AS_L = 1'b1;
    repeat (2) step("write_end");

    SRamSelect_H = 1'b0; AS_L = 1'b0;
    repeat (10) step("nosel");
    AS_L = 1'b1;
    step("nosel_end");

    SRamSelect_H = 1'b1; AS_L = 1'b0;
    repeat (3) step("abort");
    AS_L = 1'b1;
    repeat (2) step("abort_end");

    AS_L = 1'b0;
    repeat (4) step("pre_rst");
    pulse_reset();
    repeat (5) step("post_rst");
    AS_L = 1'b1;
    step("rearm");
    AS_L = 1'b0;
    repeat (20) step("after_rst");
    AS_L = 1'b1;
    step("after_rst_end");

    repeat (60) begin
      int lo;
      rand_fields();
      lo   = $urandom_range(0, 24);
      AS_L = 1'b0;
      for (int j = 0; j < lo; j++) begin
        step("rand");
        if ($urandom_range(0, 9) < 3) rand_fields();
        if ($urandom_range(0, 39) == 0) pulse_reset();
      end
      AS_L = 1'b1;
      repeat ($urandom_range(1, 3)) step("rand_gap");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
